// File: rtl/router_pkg.sv
// Shared constants and types for the router input-port receiver and its
// packet FIFO.
package router_pkg;

  localparam int NUM_PORTS = 8;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PAD,
    DATA,
    DRAIN
  } rx_state_t;

  typedef struct packed {
    logic [2:0]        da;
    logic [DATA_W-1:0] data;
  } pkt_t;

endpackage

// File: rtl/router_pkt_fifo.sv
// Show-ahead register FIFO for received packets. A push while full is taken
// only when a pop frees the head entry in the same cycle.
module router_pkt_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = router_pkg::pkt_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  output logic full,
  input  logic pop,
  output T     pop_data,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/router_in_port.sv
// Per-port serial receiver: deserialises frame_n/valid_n/di frames into
// (destination, payload) packets and queues them for the switch core.
module router_in_port
  import router_pkg::*;
#(
  parameter int MAX_PAD = 15,
  parameter int DEPTH   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              di,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_da,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err_pulse,
  output logic              drop_pulse
);

  localparam int PAD_W = $clog2(MAX_PAD + 1);
  localparam int BIT_W = $clog2(DATA_W);

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic              frame_n_q;
  logic              frame_start;
  logic [1:0]        addr_cnt_q;
  logic [PAD_W-1:0]  pad_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [ADDR_W-1:0] da_q;
  logic [DATA_W-1:0] data_q;
  logic              last_bit;
  logic              pad_over;
  logic              da_bad;
  logic              shift_da;
  logic              shift_data;
  logic              push_req;
  logic              err_set;
  logic              drop_set;
  logic              fifo_full;
  logic              fifo_empty;
  pkt_t              push_pkt;
  pkt_t              head_pkt;

  // A frame starts only on a sampled high-to-low edge of frame_n. This also
  // makes the tail of a frame cut short by reset look like a drained frame.
  always_ff @(posedge clock) begin
    frame_n_q <= frame_n;
  end

  assign frame_start = frame_n_q && !frame_n;
  assign last_bit    = (state_q == DATA) && !valid_n && (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign pad_over    = (pad_cnt_q == PAD_W'(MAX_PAD));
  assign da_bad      = (da_q >= ADDR_W'(NUM_PORTS));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (frame_start) state_d = ADDR;
      ADDR: begin
        if (frame_n) state_d = IDLE;
        else if (addr_cnt_q == 2'd3) state_d = PAD;
      end
      PAD: begin
        if (frame_n) state_d = IDLE;
        else if (!valid_n) state_d = DATA;
        else if (pad_over) state_d = DRAIN;
      end
      DATA: begin
        if (last_bit) state_d = frame_n ? IDLE : DRAIN;
        else if (frame_n) state_d = IDLE;
      end
      DRAIN: if (frame_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_da   = 1'b0;
    shift_data = 1'b0;
    push_req   = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      IDLE: shift_da = frame_start;
      ADDR: begin
        shift_da = !frame_n;
        err_set  = frame_n;
      end
      PAD: begin
        shift_data = !frame_n && !valid_n;
        err_set    = frame_n || (valid_n && pad_over);
      end
      DATA: begin
        shift_data = !valid_n && (last_bit || !frame_n);
        if (last_bit) begin
          push_req = frame_n && !da_bad;
          err_set  = !frame_n || da_bad;
        end else begin
          err_set  = frame_n;
        end
      end
      DRAIN: ;
      default: ;
    endcase
  end

  // Address and payload arrive LSB first, so both shift in from the top.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_cnt_q <= '0;
      pad_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      da_q       <= '0;
      data_q     <= '0;
    end else begin
      if (shift_da) begin
        da_q       <= {di, da_q[ADDR_W-1:1]};
        addr_cnt_q <= (state_q == IDLE) ? 2'd1 : addr_cnt_q + 2'd1;
      end
      pad_cnt_q <= (state_q == PAD && valid_n) ? pad_cnt_q + PAD_W'(1) : '0;
      if (shift_data) begin
        data_q    <= {di, data_q[DATA_W-1:1]};
        bit_cnt_q <= (state_q == PAD) ? BIT_W'(1) : bit_cnt_q + BIT_W'(1);
      end
    end
  end

  assign push_pkt = {da_q[2:0], di, data_q[DATA_W-1:1]};
  assign drop_set = push_req && fifo_full && !out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_pulse  <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      err_pulse  <= err_set;
      drop_pulse <= drop_set;
    end
  end

  // out_valid/out_ready: the head packet moves on every cycle where both are
  // high; while out_valid waits for out_ready the head entry does not change.
  router_pkt_fifo #(
    .DEPTH(DEPTH),
    .T    (pkt_t)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_req),
    .push_data(push_pkt),
    .full     (fifo_full),
    .pop      (out_ready),
    .pop_data (head_pkt),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_da    = head_pkt.da;
  assign out_data  = head_pkt.data;
  assign busy      = (state_q != IDLE);

endmodule
